rf_host_bridge: RTL and testbench

Upstream front-end for the generated register files. Accepts single-beat host read/write requests on a valid/ready channel and converts them into the register file's software interface. That interface is `address`, `read_en`, `write_en` and `write_data` out, and `read_data`, `access_complete` and `invalid_address` in. It returns exactly one response per request, carrying read data and an error code, and applies local range checking plus a completion timeout so the host is never left hanging.

---
 rtl/rf_host_bridge_pkg.sv | 27 ++
 rtl/rf_host_bridge.sv | 172 +++++++++++++++++
 tb/tb_rf_host_bridge.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rf_host_bridge_pkg.sv
// Shared types and default widths for the host-to-register-file bridge.
package rf_host_bridge_pkg;

  localparam int DEF_HOST_ADDR_W = 16;
  localparam int DEF_RF_ADDR_LO  = 3;
  localparam int DEF_RF_ADDR_HI  = 3;
  localparam int DEF_DATA_W      = 64;
  localparam int DEF_TIMEOUT     = 16;

  // Width of the WAIT-state timeout counter; covers TIMEOUT values up to 255.
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_INVALID = 2'd1,
    ERR_RANGE   = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

endpackage

// File: rtl/rf_host_bridge.sv
// Single-beat host request front-end for a generated register file.
// Range-checks the host address, issues one RF strobe, waits for completion
// (bounded by a timeout) and returns exactly one response per request.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | req_ready high, waiting for a host request
// ISSUE | one-cycle read_en/write_en strobe; completion already sampled
// WAIT  | strobe low, address/data held, timeout counter running
// RESP  | rsp_valid high, response held until rsp_ready
module rf_host_bridge
  import rf_host_bridge_pkg::*;
#(
  parameter int HOST_ADDR_W = DEF_HOST_ADDR_W,
  parameter int RF_ADDR_LO  = DEF_RF_ADDR_LO,
  parameter int RF_ADDR_HI  = DEF_RF_ADDR_HI,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         res_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [HOST_ADDR_W-1:0]       req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic [1:0]                   rsp_err,
  output logic [RF_ADDR_HI:RF_ADDR_LO] address,
  output logic                         read_en,
  output logic                         write_en,
  output logic [DATA_W-1:0]            write_data,
  input  logic [DATA_W-1:0]            read_data,
  input  logic                         access_complete,
  input  logic                         invalid_address
);

  state_t                      r_state, w_state_nxt;
  logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
  logic                        r_write, w_write_nxt;
  logic                        r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]           r_rsp_rdata, w_rsp_rdata_nxt;
  err_t                        r_rsp_err, w_rsp_err_nxt;
  logic [RF_ADDR_HI:RF_ADDR_LO] r_address, w_address_nxt;
  logic                        r_read_en, w_read_en_nxt;
  logic                        r_write_en, w_write_en_nxt;
  logic [DATA_W-1:0]           r_write_data, w_write_data_nxt;
  logic                        w_out_of_range;
  logic                        w_timeout;

  // Any host address bit above the RF word range makes the request out of range.
  assign w_out_of_range = (req_addr >> (RF_ADDR_HI + 1)) != '0;

  // Last WAIT cycle before giving up: TIMEOUT cycles spent in WAIT in total.
  assign w_timeout = (r_state == WAIT) && (r_cnt == CNT_W'(TIMEOUT - 1));

  // Next-state and next-output decode; strobes default low so they pulse once.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_write_nxt      = r_write;
    w_rsp_valid_nxt  = r_rsp_valid;
    w_rsp_rdata_nxt  = r_rsp_rdata;
    w_rsp_err_nxt    = r_rsp_err;
    w_address_nxt    = r_address;
    w_write_data_nxt = r_write_data;
    w_read_en_nxt    = 1'b0;
    w_write_en_nxt   = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (req_valid) begin
          if (w_out_of_range) begin
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = ERR_RANGE;
            w_rsp_rdata_nxt = '0;
            w_state_nxt     = RESP;
          end else begin
            w_address_nxt    = req_addr[RF_ADDR_HI:RF_ADDR_LO];
            w_write_data_nxt = req_wdata;
            w_write_nxt      = req_write;
            w_read_en_nxt    = ~req_write;
            w_write_en_nxt   = req_write;
            w_state_nxt      = ISSUE;
          end
        end
      end

      ISSUE, WAIT: begin
        if (invalid_address) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = ERR_INVALID;
          w_rsp_rdata_nxt = '0;
          w_state_nxt     = RESP;
        end else if (access_complete) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = ERR_OK;
          w_rsp_rdata_nxt = r_write ? '0 : read_data;
          w_state_nxt     = RESP;
        end else if (w_timeout) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_err_nxt   = ERR_TIMEOUT;
          w_rsp_rdata_nxt = '0;
          w_state_nxt     = RESP;
        end else begin
          w_state_nxt = WAIT;
          if (r_state == WAIT) begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end

      RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_rsp_err_nxt   = ERR_OK;
          w_rsp_rdata_nxt = '0;
          w_state_nxt     = IDLE;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  // State, direction and timeout counter registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_write <= w_write_nxt;
    end
  end

  // Registered host response and RF-side outputs; reset drops strobes at once.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_err    <= ERR_OK;
      r_address    <= '0;
      r_read_en    <= 1'b0;
      r_write_en   <= 1'b0;
      r_write_data <= '0;
    end else begin
      r_rsp_valid  <= w_rsp_valid_nxt;
      r_rsp_rdata  <= w_rsp_rdata_nxt;
      r_rsp_err    <= w_rsp_err_nxt;
      r_address    <= w_address_nxt;
      r_read_en    <= w_read_en_nxt;
      r_write_en   <= w_write_en_nxt;
      r_write_data <= w_write_data_nxt;
    end
  end

  assign req_ready  = (r_state == IDLE);
  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  assign address    = r_address;
  assign read_en    = r_read_en;
  assign write_en   = r_write_en;
  assign write_data = r_write_data;

endmodule

// File: tb/tb_rf_host_bridge.sv
// Self-checking bench for rf_host_bridge: directed vector table, hand-written
// corner sequences, then randomized traffic against a transaction-level model.
module tb_rf_host_bridge;
  import rf_host_bridge_pkg::*;

  localparam int TO = DEF_TIMEOUT;

  logic        clk = 1'b0;
  logic        res_n;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic [3:3]  address;
  logic        read_en, write_en;
  logic [63:0] write_data;
  logic [63:0] read_data;
  logic        access_complete, invalid_address;

  rf_host_bridge #(
    .HOST_ADDR_W(16), .RF_ADDR_LO(3), .RF_ADDR_HI(3), .DATA_W(64), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .res_n(res_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .address(address), .read_en(read_en), .write_en(write_en), .write_data(write_data),
    .read_data(read_data), .access_complete(access_complete), .invalid_address(invalid_address)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_err = 0;
  int n_checks = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // RF stand-in: registered, answers one cycle after the strobe.
  // rf_mode 0 = complete, 1 = invalid_address, 2 = both, 3 = never answers.
  int          rf_mode = 0;
  int          inj_cycles = 0;
  int          rd_pulses = 0;
  int          wr_pulses = 0;
  int          last_addr = -1;
  bit          both_seen = 1'b0;
  logic [63:0] rf_mem [2];

  initial begin
    bit         pend;
    bit         pend_wr;
    logic [3:3] pend_a;
    rf_mem[0] = '0;
    rf_mem[1] = '0;
    pend = 1'b0;
    pend_wr = 1'b0;
    pend_a = '0;
    access_complete = 1'b0;
    invalid_address = 1'b0;
    read_data = '0;
    forever begin
      @(negedge clk);
      access_complete = 1'b0;
      invalid_address = 1'b0;
      if (inj_cycles > 0) begin
        access_complete = 1'b1;
        inj_cycles--;
      end
      if (pend) begin
        case (rf_mode)
          0: begin
            access_complete = 1'b1;
            if (!pend_wr) read_data = rf_mem[pend_a];
          end
          1: invalid_address = 1'b1;
          2: begin
            access_complete = 1'b1;
            invalid_address = 1'b1;
          end
          default: ;
        endcase
      end
      pend = 1'b0;
      if (read_en || write_en) begin
        pend = 1'b1;
        pend_wr = write_en;
        pend_a = address;
        last_addr = int'(address);
        if (read_en) rd_pulses++;
        if (write_en) wr_pulses++;
        if (read_en && write_en) both_seen = 1'b1;
        if (write_en && rf_mode == 0) rf_mem[address] = write_data;
      end
    end
  end

  // Transaction-level reference: a 2-word memory and the error/latency rules.
  logic [63:0] ref_mem [2];

  function automatic void ref_model(input bit wr, input logic [15:0] a, input logic [63:0] wd,
                                    input int mode, output logic [1:0] e, output logic [63:0] d,
                                    output int lat, output int rdp, output int wrp);
    int idx;
    idx = (int'(a) / 8) % 2;
    d = '0;
    rdp = 0;
    wrp = 0;
    if (int'(a) >= 16) begin
      e = 2'd2;
      lat = 1;
      return;
    end
    if (wr) wrp = 1; else rdp = 1;
    lat = 3;
    case (mode)
      0: begin
        e = 2'd0;
        if (wr) ref_mem[idx] = wd;
        else d = ref_mem[idx];
      end
      1, 2: e = 2'd1;
      default: begin
        e = 2'd3;
        lat = TO + 2;
      end
    endcase
  endfunction

  // One host transaction: request, wait for response, optional backpressure, handshake.
  task automatic do_txn(input bit wr, input logic [15:0] a, input logic [63:0] wd, input int mode,
                        input int hold, input logic [1:0] e_err, input logic [63:0] e_data,
                        output int lat, output int rdp, output int wrp);
    int t;
    int n;
    int rd0;
    int wr0;
    @(negedge clk);
    rf_mode = mode;
    req_valid = 1'b1;
    req_write = wr;
    req_addr = a;
    req_wdata = wd;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("req_accept", 64'(req_ready), 64'd1);
    rd0 = rd_pulses;
    wr0 = wr_pulses;
    last_addr = -1;
    @(posedge clk);
    @(negedge clk);
    n = cyc;
    req_valid = 1'b0;
    t = 0;
    while (!rsp_valid && t < TO + 10) begin
      @(negedge clk);
      t++;
    end
    lat = cyc - n + 1;
    check("rsp_valid_seen", 64'(rsp_valid), 64'd1);
    check("rsp_err", 64'(rsp_err), 64'(e_err));
    check("rsp_rdata", rsp_rdata, e_data);
    check("req_ready_busy", 64'(req_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(rsp_valid), 64'd1);
      check("hold_err", 64'(rsp_err), 64'(e_err));
      check("hold_rdata", rsp_rdata, e_data);
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_drop", 64'(rsp_valid), 64'd0);
    check("ready_after_hs", 64'(req_ready), 64'd1);
    rdp = rd_pulses - rd0;
    wrp = wr_pulses - wr0;
  endtask

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [63:0] wdata;
    int          mode;
    int          hold;
    logic [1:0]  e_err;
    logic [63:0] e_data;
    int          e_lat;
    int          e_rd;
    int          e_wr;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int          lat, rdp, wrp, cnt, rd0, wr0;
    logic [1:0]  e;
    logic [63:0] d;
    int          elat, erd, ewr, mode, r;
    bit          wr;
    logic [15:0] a;
    logic [63:0] wd;

    vecs[0] = '{1'b1, 16'h0000, 64'h555AAA555AAA555A, 0, 0, 2'd0, 64'h0, 3, 0, 1};
    vecs[1] = '{1'b0, 16'h0000, 64'h0, 0, 0, 2'd0, 64'h555AAA555AAA555A, 3, 1, 0};
    vecs[2] = '{1'b1, 16'h000F, 64'h0123456789ABCDEF, 0, 0, 2'd0, 64'h0, 3, 0, 1};
    vecs[3] = '{1'b0, 16'h0008, 64'h0, 0, 1, 2'd0, 64'h0123456789ABCDEF, 3, 1, 0};
    vecs[4] = '{1'b0, 16'h0008, 64'h0, 1, 0, 2'd1, 64'h0, 3, 1, 0};
    vecs[5] = '{1'b0, 16'h0010, 64'h0, 0, 0, 2'd2, 64'h0, 1, 0, 0};
    vecs[6] = '{1'b1, 16'h8000, 64'hFFFF0000FFFF0000, 0, 0, 2'd2, 64'h0, 1, 0, 0};
    vecs[7] = '{1'b1, 16'h0008, 64'hA5A5A5A5A5A5A5A5, 2, 5, 2'd1, 64'h0, 3, 0, 1};
    vecs[8] = '{1'b0, 16'h0000, 64'h0, 3, 0, 2'd3, 64'h0, TO + 2, 1, 0};

    res_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    check("rst_rsp_err", 64'(rsp_err), 64'd0);
    check("rst_address", 64'(address), 64'd0);
    check("rst_strobes", 64'({read_en, write_en}), 64'd0);
    check("rst_write_data", write_data, 64'd0);
    res_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].mode, vecs[i].hold,
             vecs[i].e_err, vecs[i].e_data, lat, rdp, wrp);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].e_lat));
      check($sformatf("vec%0d_rd_pulses", i), 64'(rdp), 64'(vecs[i].e_rd));
      check($sformatf("vec%0d_wr_pulses", i), 64'(wrp), 64'(vecs[i].e_wr));
      if (vecs[i].e_rd + vecs[i].e_wr > 0)
        check($sformatf("vec%0d_address", i), 64'(last_addr), 64'(vecs[i].addr[3]));
    end

    // Late completion after the timeout must not create a second response.
    inj_cycles = 2;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("late_cmpl_no_rsp", 64'(cnt), 64'd0);
    check("late_cmpl_ready", 64'(req_ready), 64'd1);

    // Reset while the write strobe is high: strobe drops without a clock edge.
    @(negedge clk);
    rf_mode = 3;
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = 16'h0008;
    req_wdata = 64'hDEADBEEFCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("issue_wr_en", 64'(write_en), 64'd1);
    #1 res_n = 1'b0;
    #1;
    check("rst_issue_wr_en", 64'(write_en), 64'd0);
    check("rst_issue_wdata", write_data, 64'd0);
    @(negedge clk);
    res_n = 1'b1;

    // Reset during WAIT: no response follows after release.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 16'h0008;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("wait_address", 64'(address), 64'd1);
    #1 res_n = 1'b0;
    #1;
    check("rst_wait_address", 64'(address), 64'd0);
    check("rst_wait_strobes", 64'({read_en, write_en}), 64'd0);
    check("rst_wait_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_wait_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    res_n = 1'b1;
    rd0 = rd_pulses;
    wr0 = wr_pulses;
    cnt = 0;
    for (int i = 0; i < TO + 6; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("post_rst_no_rsp", 64'(cnt), 64'd0);
    check("post_rst_no_strobe", 64'((rd_pulses - rd0) + (wr_pulses - wr0)), 64'd0);

    // Randomized traffic against the reference model.
    ref_mem[0] = 64'h555AAA555AAA555A;
    ref_mem[1] = 64'h0123456789ABCDEF;
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      wr = 1'($urandom_range(0, 1));
      wd = {$urandom, $urandom};
      a = 16'($urandom_range(0, 15));
      mode = 0;
      if (r == 6) mode = 1;
      else if (r == 7) mode = 2;
      else if (r == 8) mode = 3;
      else if (r == 9) a = 16'($urandom_range(16, 65535));
      ref_model(wr, a, wd, mode, e, d, elat, erd, ewr);
      do_txn(wr, a, wd, mode, $urandom_range(0, 3), e, d, lat, rdp, wrp);
      check($sformatf("rnd%0d_latency", k), 64'(lat), 64'(elat));
      check($sformatf("rnd%0d_rd_pulses", k), 64'(rdp), 64'(erd));
      check($sformatf("rnd%0d_wr_pulses", k), 64'(wrp), 64'(ewr));
      if (erd + ewr > 0)
        check($sformatf("rnd%0d_address", k), 64'(last_addr), 64'(a[3]));
    end

    check("no_dual_strobe", 64'(both_seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
